// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: combinational ROM read port plus the valid/ready path toward decode.
interface fetch_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  dec_valid;
    logic                  dec_ready;
    logic [DATA_WIDTH-1:0] dec_instr;
    logic [ADDR_WIDTH-1:0] dec_pc;

    modport master (
        output rom_addr,
        input  rom_data,
        output dec_valid,
        input  dec_ready,
        output dec_instr,
        output dec_pc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  dec_valid,
        output dec_ready,
        input  dec_instr,
        input  dec_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC ownership, 2-entry fetch queue to decode, branch flush, HALT stop.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  branch_en,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    fetch_ctrl_if.master          bus,
    output logic                  halted
`ifdef FETCH_CTRL_PERF_EN
   ,output logic [15:0]           perf_stall_cnt,
    output logic [15:0]           perf_flush_cnt
`endif
);

    localparam int unsigned CNT_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    entry_t                head_q, head_d;
    entry_t                tail_q, tail_d;
    logic                  dec_valid_q, dec_valid_d;
    logic                  halted_q, halted_d;

    logic                  pop;
    logic                  push;
    logic                  flush;
    entry_t                fetched;

    assign pop     = dec_valid_q & bus.dec_ready;
    assign fetched = '{pc: pc_q, instr: bus.rom_data};

    // Next-state, PC and queue update; branch redirect outranks any fetch in the same cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        push        = 1'b0;
        flush       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_HALT: begin
                if (branch_en) begin
                    flush   = 1'b1;
                    pc_d    = branch_addr;
                    state_d = ST_RUN;
                end else if ((state_q == ST_RUN) && ((count_q != CNT_WIDTH'(2)) || pop)) begin
                    push = 1'b1;
                    pc_d = pc_q + ADDR_WIDTH'(1);
                    if (bus.rom_data[DATA_WIDTH-1 -: 4] == HALT_OPCODE) begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == CNT_WIDTH'(0)) begin
                        head_d = fetched;
                    end else begin
                        tail_d = fetched;
                    end
                    count_d = count_q + CNT_WIDTH'(1);
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - CNT_WIDTH'(1);
                end
                2'b11: begin
                    if (count_q == CNT_WIDTH'(1)) begin
                        head_d = fetched;
                    end else begin
                        head_d = tail_q;
                        tail_d = fetched;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end

        dec_valid_d = (count_d != CNT_WIDTH'(0));
        halted_d    = (state_d == ST_HALT) && (count_d == CNT_WIDTH'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            dec_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            dec_valid_q <= dec_valid_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.rom_addr  = pc_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.dec_instr = head_q.instr;
    assign bus.dec_pc    = head_q.pc;
    assign halted        = halted_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        stall_inc;

    assign stall_inc = (state_q == ST_RUN) && (count_q == CNT_WIDTH'(2)) && !pop;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: ROM model, expected-word scoreboard, scenario tasks.
module tb_fetch_ctrl;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        branch_en;
    logic [7:0]  branch_addr;
    logic        halted;
    logic [15:0] rom [256];
    exp_t        exp_q [$];
    exp_t        e;
    int          checks;
    int          errors;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    fetch_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    fetch_ctrl #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (16),
        .RESET_PC   (8'h00),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .branch_en  (branch_en),
        .branch_addr(branch_addr),
        .bus        (bus.master),
        .halted     (halted)
`ifdef FETCH_CTRL_PERF_EN
       ,.perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    assign bus.rom_data = rom[bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [7:0] base, input int n);
        logic [7:0] a;
        for (int k = 0; k < n; k++) begin
            a = base + 8'(k);
            exp_q.push_back('{pc: a, instr: rom[a]});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.dec_valid); end
        checks++; if (bus.dec_instr !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h want 0000", bus.dec_instr); end
        checks++; if (bus.dec_pc !== 8'h0) begin errors++; $display("FAIL reset_pc: got %h want 00", bus.dec_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (bus.rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr: got %h want 00", bus.rom_addr); end
        reset       = 1'b0;
        branch_en   = 1'b1;
        branch_addr = 8'h33;
        @(posedge clk); #1;
        branch_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.rom_addr !== 8'h00) begin errors++; $display("FAIL idle_branch_addr: got %h want 00", bus.rom_addr); end
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", bus.dec_valid); end
    endtask

    task automatic test_stream();
        push_exp(8'h00, 4);
        bus.dec_ready = 1'b1;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL start_latency0: got %b want 0", bus.dec_valid); end
        @(posedge clk); #1;
        checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 8'h00) begin errors++; $display("FAIL start_latency1: got valid=%b pc=%h want valid=1 pc=00", bus.dec_valid, bus.dec_pc); end
        for (int i = 0; i < 20; i++) begin
            if (bus.dec_valid && bus.dec_ready) begin
                e = exp_q.pop_front(); checks++;
                if ({bus.dec_pc, bus.dec_instr} !== e) begin errors++; $display("FAIL stream_word: got %h/%h want %h/%h", bus.dec_pc, bus.dec_instr, e.pc, e.instr); end
            end
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL stream_timeout: %0d words left want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_backpressure();
        logic [7:0] freeze;
        @(posedge clk); #1;
        push_exp(bus.dec_pc, 4);
        freeze        = bus.dec_pc + 8'd2;
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.rom_addr !== freeze || bus.dec_valid !== 1'b1 || bus.dec_pc !== exp_q[0].pc) begin
                errors++; $display("FAIL stall_hold: got addr=%h valid=%b pc=%h want addr=%h valid=1 pc=%h", bus.rom_addr, bus.dec_valid, bus.dec_pc, freeze, exp_q[0].pc);
            end
        end
        bus.dec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.dec_valid && bus.dec_ready) begin
                e = exp_q.pop_front(); checks++;
                if ({bus.dec_pc, bus.dec_instr} !== e) begin errors++; $display("FAIL release_word: got %h/%h want %h/%h", bus.dec_pc, bus.dec_instr, e.pc, e.instr); end
            end
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL release_timeout: %0d words left want 0", exp_q.size()); exp_q.delete(); end
`ifdef FETCH_CTRL_PERF_EN
        checks++; if (perf_stall_cnt !== 16'd4) begin errors++; $display("FAIL perf_stall: got %0d want 4", perf_stall_cnt); end
`endif
    endtask

    task automatic test_branch_full();
        @(posedge clk); #1;
        bus.dec_ready = 1'b0;
        @(posedge clk); #1;
        branch_en   = 1'b1;
        branch_addr = 8'h40;
        @(posedge clk); #1;
        branch_en     = 1'b0;
        bus.dec_ready = 1'b1;
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL branch_flush: got valid=%b want 0", bus.dec_valid); end
        push_exp(8'h40, 4);
        @(posedge clk); #1;
        checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 8'h40) begin errors++; $display("FAIL branch_target: got valid=%b pc=%h want valid=1 pc=40", bus.dec_valid, bus.dec_pc); end
        for (int i = 0; i < 20; i++) begin
            if (bus.dec_valid && bus.dec_ready) begin
                e = exp_q.pop_front(); checks++;
                if ({bus.dec_pc, bus.dec_instr} !== e) begin errors++; $display("FAIL branch_word: got %h/%h want %h/%h", bus.dec_pc, bus.dec_instr, e.pc, e.instr); end
            end
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL branch_timeout: %0d words left want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_halt();
        @(posedge clk); #1;
        rom[5]      = 16'hF000;
        branch_en   = 1'b1;
        branch_addr = 8'h03;
        @(posedge clk); #1;
        branch_en = 1'b0;
        push_exp(8'h03, 3);
        for (int i = 0; i < 20; i++) begin
            if (bus.dec_valid && bus.dec_ready) begin
                e = exp_q.pop_front(); checks++;
                if ({bus.dec_pc, bus.dec_instr} !== e) begin errors++; $display("FAIL halt_word: got %h/%h want %h/%h", bus.dec_pc, bus.dec_instr, e.pc, e.instr); end
            end
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL halt_timeout: %0d words left want 0", exp_q.size()); exp_q.delete(); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_drain: got halted=%b want 0", halted); end
        @(posedge clk); #1;
        checks++; if (halted !== 1'b1 || bus.dec_valid !== 1'b0 || bus.rom_addr !== 8'h06) begin errors++; $display("FAIL halt_stop: got halted=%b valid=%b addr=%h want 1 0 06", halted, bus.dec_valid, bus.rom_addr); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (halted !== 1'b1 || bus.rom_addr !== 8'h06) begin errors++; $display("FAIL halt_start_ignored: got halted=%b addr=%h want 1 06", halted, bus.rom_addr); end
        branch_en   = 1'b1;
        branch_addr = 8'h10;
        @(posedge clk); #1;
        branch_en = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_resume: got halted=%b want 0", halted); end
        push_exp(8'h10, 3);
        for (int i = 0; i < 20; i++) begin
            if (bus.dec_valid && bus.dec_ready) begin
                e = exp_q.pop_front(); checks++;
                if ({bus.dec_pc, bus.dec_instr} !== e) begin errors++; $display("FAIL resume_word: got %h/%h want %h/%h", bus.dec_pc, bus.dec_instr, e.pc, e.instr); end
            end
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL resume_timeout: %0d words left want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_wrap();
        @(posedge clk); #1;
        branch_en   = 1'b1;
        branch_addr = 8'hFE;
        @(posedge clk); #1;
        branch_en = 1'b0;
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL wrap_flush: got valid=%b want 0", bus.dec_valid); end
        push_exp(8'hFE, 4);
        for (int i = 0; i < 20; i++) begin
            if (bus.dec_valid && bus.dec_ready) begin
                e = exp_q.pop_front(); checks++;
                if ({bus.dec_pc, bus.dec_instr} !== e) begin errors++; $display("FAIL wrap_word: got %h/%h want %h/%h", bus.dec_pc, bus.dec_instr, e.pc, e.instr); end
            end
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL wrap_timeout: %0d words left want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #1;
`ifdef FETCH_CTRL_PERF_EN
        checks++; if (perf_flush_cnt !== 16'd4) begin errors++; $display("FAIL perf_flush: got %0d want 4", perf_flush_cnt); end
`endif
        bus.dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b1;
        branch_en   = 1'b1;
        branch_addr = 8'h55;
        @(posedge clk); #1;
        checks++; if (bus.dec_valid !== 1'b0 || bus.rom_addr !== 8'h00 || halted !== 1'b0) begin errors++; $display("FAIL midreset: got valid=%b addr=%h halted=%b want 0 00 0", bus.dec_valid, bus.rom_addr, halted); end
`ifdef FETCH_CTRL_PERF_EN
        checks++; if (perf_stall_cnt !== 16'd0 || perf_flush_cnt !== 16'd0) begin errors++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt); end
`endif
        reset         = 1'b0;
        branch_en     = 1'b0;
        bus.dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.dec_valid !== 1'b0 || bus.rom_addr !== 8'h00) begin errors++; $display("FAIL post_reset_idle: got valid=%b addr=%h want 0 00", bus.dec_valid, bus.rom_addr); end
        end
        start       = 1'b1;
        branch_en   = 1'b1;
        branch_addr = 8'h70;
        push_exp(8'h00, 3);
        @(posedge clk); #1;
        start     = 1'b0;
        branch_en = 1'b0;
        checks++; if (bus.rom_addr !== 8'h00) begin errors++; $display("FAIL start_over_branch: got addr=%h want 00", bus.rom_addr); end
        for (int i = 0; i < 20; i++) begin
            if (bus.dec_valid && bus.dec_ready) begin
                e = exp_q.pop_front(); checks++;
                if ({bus.dec_pc, bus.dec_instr} !== e) begin errors++; $display("FAIL restart_word: got %h/%h want %h/%h", bus.dec_pc, bus.dec_instr, e.pc, e.instr); end
            end
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL restart_timeout: %0d words left want 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        start         = 1'b0;
        branch_en     = 1'b0;
        branch_addr   = 8'h00;
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
        rom[0] = 16'h0A0A;
        rom[1] = 16'h0B0B;
        rom[2] = 16'h0C0C;
        rom[3] = 16'h0D0D;

        test_reset();
        test_stream();
        test_backpressure();
        test_branch_full();
        test_halt();
        test_wrap();
        test_reset_midstream();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
